alu_control_decoder: RTL and testbench
======================================

// Module: alu_control_decoder
//
// PURPOSE
// - Registered ALU-control decoder for the single-issue MIPS datapath; sits between
//   the main control unit and the ALU.
// - Maps the 6-bit instruction opcode and, for R-type, the 6-bit funct field to a
//   4-bit ALU operation select. The select is registered with 1-cycle latency.
// - Flags opcode/funct combinations it does not support.
//
// PARAMETERS
// - none (all widths fixed: opcode 6, funct 6, control 4)
//
// PORTS
// - clk          input   1  rising-edge clock; the block's only clock
// - rst_n        input   1  asynchronous, active-low reset
// - en           input   1  load enable; 1 = capture a new decode at the clock edge
// - alu_op       input   6  instruction opcode [31:26]
// - funct        input   6  instruction funct [5:0]; used only when alu_op==6'h00
// - alu_control  output  4  registered ALU operation select
// - illegal      output  1  registered; 1 = unsupported opcode/funct combination
//
// BEHAVIOUR
// - ALU select codes: AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100,
//   SUB=0110, SLT=0111, SLTU=1000, NOR=1100. All other codes are never produced.
// - R-type decode (alu_op=6'h00), keyed on funct:
//   - 20 ADD; 21 ADD (addu); 22 SUB; 23 SUB (subu)
//   - 24 AND; 25 OR; 27 NOR; 2A SLT; 2B SLTU; 00 SLL; 02 SRL
//   - any other funct -> ADD with illegal=1
// - I-type decode, keyed on alu_op; funct is ignored:
//   - 08 addi -> ADD
//   - 23 lw, 21 lh, 25 lhu, 2B sw -> ADD (address computation)
//   - 0C andi -> AND; 0D ori -> OR
//   - 04 beq -> SUB (operand compare)
//   - any other opcode -> ADD with illegal=1
// - Decode is purely combinational. Its result is captured into alu_control and
//   illegal on the rising clk edge where en=1.
// - Latency: output reflects the inputs sampled at the previous enabled edge.
// - en=0: both outputs hold their previous value; input changes have no effect.
// - Reset: while rst_n=0, alu_control=4'b0000 and illegal=0, asynchronously and
//   independent of clk. Reset asserted mid-operation overrides any pending capture.
// - First capture after reset release occurs at the first rising edge with rst_n=1
//   and en=1.
// - No X propagation: every 12-bit input combination maps to a defined code.
// - Inputs must be stable around the rising clk edge (normal setup/hold).
//
// TESTING
// - Reset: rst_n=0 with alu_op=00, funct=22, en=1, clock running ->
//   alu_control=0000, illegal=0. Release reset; next edge -> 0110.
// - R-type sweep, en=1, alu_op=00, one funct per edge, checking the result one edge later:
//   20->0010, 22->0110, 00->0011, 02->0100, 24->0000, 25->0001, 27->1100,
//   2A->0111, 2B->1000; illegal=0 throughout.
// - I-type sweep, en=1, funct=14 (don't-care), checking the result one edge later:
//   alu_op 08->0010, 23->0010, 21->0010, 25->0010, 2B->0010, 0C->0000,
//   0D->0001, 04->0110.
// - Illegal inputs: alu_op=00, funct=3F -> 0010 with illegal=1; alu_op=3F -> 0010 with
//   illegal=1; next legal input (alu_op=0C) -> 0000 with illegal=0.
// - Enable hold: capture alu_op=0D (0001), then en=0 and apply alu_op=04 for
//   3 edges -> output stays 0001. Set en=1 -> next edge 0110.
// - Async reset mid-stream: assert rst_n=0 between edges while the output is 0110 ->
//   the output goes to 0000 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/alu_control_decoder.sv
// Registered ALU-control decoder: maps opcode/funct to a 4-bit ALU select plus an
// illegal-combination flag, captured one cycle after an enabled edge.
module alu_control_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Returns {illegal, select}; unsupported combinations fall back to ADD.
  function automatic logic [4:0] decode(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] sel;
    logic       bad;
    sel = ALU_ADD;
    bad = 1'b0;
    if (op == OP_RTYPE) begin
      case (fn)
        6'h20, 6'h21: sel = ALU_ADD;
        6'h22, 6'h23: sel = ALU_SUB;
        6'h24:        sel = ALU_AND;
        6'h25:        sel = ALU_OR;
        6'h27:        sel = ALU_NOR;
        6'h2A:        sel = ALU_SLT;
        6'h2B:        sel = ALU_SLTU;
        6'h00:        sel = ALU_SLL;
        6'h02:        sel = ALU_SRL;
        default:      bad = 1'b1;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW: sel = ALU_ADD;
        OP_ANDI: sel = ALU_AND;
        OP_ORI:  sel = ALU_OR;
        OP_BEQ:  sel = ALU_SUB;
        default: bad = 1'b1;
      endcase
    end
    return {bad, sel};
  endfunction

  logic [3:0] ctrl_p0;
  logic       illegal_p0;
  logic [3:0] ctrl_p1;
  logic       illegal_p1;

  // Stage p0: combinational decode
  always_comb begin
    {illegal_p0, ctrl_p0} = decode(alu_op, funct);
  end

  // Stage p1: registered result, held while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p1    <= ALU_AND;
      illegal_p1 <= 1'b0;
    end else if (en) begin
      ctrl_p1    <= ctrl_p0;
      illegal_p1 <= illegal_p0;
    end
  end

  assign alu_control = ctrl_p1;
  assign illegal     = illegal_p1;

endmodule

// File: tb/tb_alu_control_decoder.sv
// Self-checking bench for alu_control_decoder: directed steps followed by
// randomized vectors checked against a table-driven reference model.
module tb_alu_control_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [5:0] alu_op;
  logic [5:0] funct;
  logic [3:0] alu_control;
  logic       illegal;

  int vectors;
  int miscompares;

  logic [3:0] rtype_map [logic [5:0]];
  logic [3:0] itype_map [logic [5:0]];

  logic [3:0] exp_ctrl;
  logic       exp_ill;

  alu_control_decoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .alu_op(alu_op),
    .funct(funct),
    .alu_control(alu_control),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lookup in the instruction tables; anything absent is ADD + illegal.
  function automatic logic [4:0] model(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (rtype_map.exists(fn)) return {1'b0, rtype_map[fn]};
      return {1'b1, 4'b0010};
    end
    if (itype_map.exists(op)) return {1'b0, itype_map[op]};
    return {1'b1, 4'b0010};
  endfunction

  task automatic check(input string tag, input logic [3:0] ec, input logic ei);
    vectors++;
    assert (alu_control === ec && illegal === ei)
    else begin
      miscompares++;
      $error("FAIL %s: observed ctrl=%b illegal=%b, expected ctrl=%b illegal=%b",
             tag, alu_control, illegal, ec, ei);
    end
  endtask

  // Drive inputs just after an edge, then check one edge later.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic e,
                      input string tag, input logic [3:0] ec, input logic ei);
    alu_op = op;
    funct  = fn;
    en     = e;
    @(posedge clk);
    #1;
    check(tag, ec, ei);
  endtask

  initial begin
    logic [5:0] r_ops [8];
    logic [5:0] r_fns [9];
    logic [3:0] r_exp [9];
    logic [5:0] op;
    logic [5:0] fn;
    logic       e;
    logic [4:0] m;

    vectors = 0;
    miscompares = 0;

    rtype_map[6'h20] = 4'b0010; rtype_map[6'h21] = 4'b0010;
    rtype_map[6'h22] = 4'b0110; rtype_map[6'h23] = 4'b0110;
    rtype_map[6'h24] = 4'b0000; rtype_map[6'h25] = 4'b0001;
    rtype_map[6'h27] = 4'b1100; rtype_map[6'h2A] = 4'b0111;
    rtype_map[6'h2B] = 4'b1000; rtype_map[6'h00] = 4'b0011;
    rtype_map[6'h02] = 4'b0100;
    itype_map[6'h08] = 4'b0010; itype_map[6'h23] = 4'b0010;
    itype_map[6'h21] = 4'b0010; itype_map[6'h25] = 4'b0010;
    itype_map[6'h2B] = 4'b0010; itype_map[6'h0C] = 4'b0000;
    itype_map[6'h0D] = 4'b0001; itype_map[6'h04] = 4'b0110;

    // Reset held with a pending capture
    rst_n = 1'b0; en = 1'b1; alu_op = 6'h00; funct = 6'h22;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 1'b0);
    rst_n = 1'b1;
    step(6'h00, 6'h22, 1'b1, "reset_release_sub", 4'b0110, 1'b0);

    // R-type sweep
    r_fns = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
    r_exp = '{4'b0010, 4'b0110, 4'b0011, 4'b0100, 4'b0000, 4'b0001, 4'b1100,
              4'b0111, 4'b1000};
    for (int i = 0; i < 9; i++)
      step(6'h00, r_fns[i], 1'b1, $sformatf("rtype_%h", r_fns[i]), r_exp[i], 1'b0);

    // I-type sweep
    r_ops = '{6'h08, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h0C, 6'h0D, 6'h04};
    r_exp[0:7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001,
                   4'b0110};
    for (int i = 0; i < 8; i++)
      step(r_ops[i], 6'h14, 1'b1, $sformatf("itype_%h", r_ops[i]), r_exp[i], 1'b0);

    // Illegal combinations and recovery
    step(6'h00, 6'h3F, 1'b1, "illegal_funct", 4'b0010, 1'b1);
    step(6'h3F, 6'h00, 1'b1, "illegal_op", 4'b0010, 1'b1);
    step(6'h0C, 6'h00, 1'b1, "legal_after_illegal", 4'b0000, 1'b0);

    // Enable hold
    step(6'h0D, 6'h00, 1'b1, "hold_capture", 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++)
      step(6'h04, 6'h00, 1'b0, $sformatf("hold_%0d", i), 4'b0001, 1'b0);
    step(6'h04, 6'h00, 1'b1, "hold_release", 4'b0110, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ctrl = 4'b0000;
    exp_ill  = 1'b0;

    // Randomized vectors against the table model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: op = 6'h00;
        1: op = r_ops[$urandom_range(0, 7)];
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 1) == 0) ? rtype_map.exists(6'($urandom)) ? 6'h2A : 6'($urandom)
                                       : 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20; 1: fn = 6'h23; 2: fn = 6'h27; 3: fn = 6'h2B; default: fn = 6'h02;
        endcase
      end
      e = ($urandom_range(0, 4) != 0);
      if (e) begin
        m = model(op, fn);
        exp_ill  = m[4];
        exp_ctrl = m[3:0];
      end
      step(op, fn, e, $sformatf("rand_%0d_op%h_fn%h_en%b", i, op, fn, e), exp_ctrl, exp_ill);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
